// File: rtl/rv_imem_port.sv
// Instruction-memory responder: sequences a wait-stated synchronous RAM read per fetch and returns one ack pulse.
// Optional macro RV_IMEM_FAULT_EN adds an address range check that answers out-of-range fetches with a fault and a NOP.
module rv_imem_port #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          MEM_ADDR_W  = 12,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_req,
  input  logic [31:2]           i_addr,
  input  logic                  i_flush,
  output logic                  o_ack,
  output logic [31:0]           o_rdata,
  output logic                  o_fault,
  output logic                  o_busy,
  output logic                  o_mem_en,
  output logic [MEM_ADDR_W-1:0] o_mem_addr,
  input  logic [31:0]           i_mem_rdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ISSUE,
    ST_DATA,
    ST_ACK
  } state_t;

  localparam int          WS_M1   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0]  WS_LOAD = 4'(WS_M1);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [MEM_ADDR_W-1:0] off_q, offset_d;
  logic                  out_of_range;
  logic                  accept;
  logic                  fault_req;

`ifdef RV_IMEM_FAULT_EN
  logic [29:0] word_off;
  // A modulo-2^30 difference below the base wraps to a huge offset, so one upper-bit test covers both ends.
  assign word_off     = i_addr - BASE_ADDR[31:2];
  assign out_of_range = |word_off[29:MEM_ADDR_W];
  assign offset_d     = word_off[MEM_ADDR_W-1:0];
`else
  assign offset_d     = MEM_ADDR_W'(i_addr - BASE_ADDR[31:2]);
  assign out_of_range = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    fault_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_req) begin
          accept = 1'b1;
          if (out_of_range) begin
            fault_req = 1'b1;
            state_d   = ST_ACK;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_ISSUE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ISSUE: state_d = ST_DATA;
      ST_DATA:  state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Redirect wins over everything; an ack already showing in ACK is not retracted.
    if (i_flush) begin
      state_d   = ST_IDLE;
      cnt_d     = 4'd0;
      accept    = 1'b0;
      fault_req = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      off_q   <= '0;
      o_rdata <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept)                         off_q   <= offset_d;
      if (state_q == ST_DATA && !i_flush) o_rdata <= i_mem_rdata;
      if (fault_req)                      o_rdata <= NOP;
    end
  end

`ifdef RV_IMEM_FAULT_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_fault <= 1'b0;
    end else begin
      if (state_q == ST_DATA && !i_flush) o_fault <= 1'b0;
      if (fault_req)                      o_fault <= 1'b1;
    end
  end
`else
  assign o_fault = 1'b0;
`endif

  assign o_ack      = (state_q == ST_ACK);
  assign o_busy     = (state_q != ST_IDLE);
  assign o_mem_en   = (state_q == ST_ISSUE);
  assign o_mem_addr = off_q;

endmodule

// File: doc/rv_imem_port.md
# rv_imem_port

Instruction-memory responder serving the fetch stage's instruction bus: accepts word-aligned fetch requests, sequences a synchronous single-port memory read with configurable wait states, and returns one registered acknowledge pulse with the instruction word. Sits between the core's fetch unit and the boot/instruction RAM. Supports request abort on PC redirect.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: byte address mapped to memory word 0.
- `MEM_ADDR_W`, default 12: memory word-address width (depth = 2^MEM_ADDR_W words).
- `WAIT_STATES`, default 0: extra cycles inserted before the memory read (0..15).

Ports:
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_reset` in 1: reset, asynchronous and active-high.
- `i_req` in 1: fetch request; held high with `i_addr` stable until `o_ack`.
- `i_addr` in [31:2]: word address of the fetch.
- `i_flush` in 1: abort any request in progress (PC redirect).
- `o_ack` in/out out 1: one-cycle response strobe; `o_rdata`/`o_fault` valid in the same cycle.
- `o_rdata` out 32: instruction word.
- `o_fault` out 1: access fault (configuration-dependent).
- `o_busy` out 1: high whenever state ≠ IDLE.
- `o_mem_en` out 1: memory read enable.
- `o_mem_addr` out MEM_ADDR_W: memory word address.
- `i_mem_rdata` in 32: memory read data, valid the cycle after `o_mem_en`.

## Operation
- States: IDLE, WAIT, ISSUE, DATA, ACK.
- IDLE: `i_req`=1 and `i_flush`=0 → latch offset = (`i_addr` − BASE_ADDR[31:2]) truncated to MEM_ADDR_W; go WAIT if WAIT_STATES>0 (counter loads WAIT_STATES−1), else ISSUE.
- WAIT: counter decrements each cycle; at 0 go ISSUE.
- ISSUE: `o_mem_en`=1, `o_mem_addr`=latched offset (both decoded from state/registers, no `i_addr` path); go DATA.
- DATA: capture `i_mem_rdata` into `o_rdata`, set `o_fault`=0; go ACK.
- ACK: `o_ack`=1 for exactly this cycle; go IDLE. `i_req` is ignored in ACK (same request still held); next request accepted in IDLE.
- `i_flush`=1 in any state: next state IDLE, counter cleared, no `o_ack` for the aborted request; in IDLE it blocks acceptance that cycle. Flush in ACK: the ack in that cycle still stands (already asserted), state returns to IDLE.
- `o_rdata` holds its last value outside ACK.
- Offset arithmetic is modulo 2^30 then truncated; no carry into fault logic unless the macro below is defined.

## Timing
- Reset values: state IDLE, counter 0, `o_ack`=0, `o_rdata`=32'h0, `o_fault`=0, `o_busy`=0, `o_mem_en`=0, `o_mem_addr`=0.
- Accept edge E0 → ISSUE cycle after E0+WAIT_STATES → `o_ack` high in the cycle after edge E0+WAIT_STATES+2; request-to-ack latency WAIT_STATES+3 cycles counting the request cycle.
- Throughput with `i_req` held continuously: one ack every WAIT_STATES+4 cycles.
- Reset asserted mid-request: immediate return to reset values, no ack, memory read abandoned.

## Configuration
- `RV_IMEM_FAULT_EN` defined: in IDLE, a request whose address lies outside [BASE_ADDR, BASE_ADDR + 4·2^MEM_ADDR_W) skips WAIT/ISSUE/DATA, goes directly to ACK (ack in the cycle after the accept edge), with `o_fault`=1, `o_rdata`=32'h0000_0013 (NOP), `o_mem_en` never asserted.
- Not defined: no range check; offset wraps modulo memory depth; `o_fault` tied 0.

## Test plan
- Reset, WAIT_STATES=0: mem word 5 = 32'hDEAD_BEEF; `i_req`=1, `i_addr`=BASE+5 → `o_mem_en` with addr 5 one cycle after accept, `o_ack`=1 with `o_rdata`=32'hDEAD_BEEF, fault 0, 3-cycle latency.
- WAIT_STATES=3, continuous `i_req` on addr 0,1,2 → acks every 7 cycles, data matches words 0,1,2, `i_req` in ACK never re-accepted.
- `i_flush` pulsed in WAIT and in DATA → no ack, `o_busy` low next cycle, following request to addr 7 completes with correct data.
- `i_req` and `i_flush` together in IDLE → no acceptance, `o_busy` stays 0.
- With `RV_IMEM_FAULT_EN`, MEM_ADDR_W=4: `i_addr`=BASE+16 → ack one cycle after accept, `o_fault`=1, `o_rdata`=32'h0000_0013, `o_mem_en` never high; without macro same address reads word 0.
- `i_reset` asserted during ISSUE → all outputs at reset values immediately, no ack after release.
